assert_fail_sequencer: RTL and testbench

//  Downstream consumer of the assertion FAILURE term (stop | ucf) in the emulation top.

---
 rtl/afs_pkg.sv | 30 +++
 rtl/afs_timestamp_ctr.sv | 21 ++
 rtl/assert_fail_sequencer.sv | 152 +++++++++++++++
 tb/tb_assert_fail_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/afs_pkg.sv
// Shared definitions for the assertion failure sequencer: FSM state
// encoding, cause bit positions and default widths.
package afs_pkg;

  localparam int TS_W_DEF      = 48;
  localparam int HOLDOFF_W_DEF = 8;
  localparam int CNT_W_DEF     = 16;

  // Bit positions inside the 2-bit cause word {stop,ucf}
  localparam int CAUSE_STOP = 1;
  localparam int CAUSE_UCF  = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_HOLDOFF = 3'd2,
    ST_HALT    = 3'd3,
    ST_REPORT  = 3'd4
  } afs_state_e;

  // Pack the two failure terms into the cause word
  function automatic logic [1:0] make_cause(input logic stop, input logic ucf);
    logic [1:0] c;
    c             = '0;
    c[CAUSE_STOP] = stop;
    c[CAUSE_UCF]  = ucf;
    return c;
  endfunction

endpackage

// File: rtl/afs_timestamp_ctr.sv
// Free-running cycle counter used as the failure timestamp.
// Counts every cycle from reset, wraps from all-ones to zero, never stops.
module afs_timestamp_ctr #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] count_o
);

  logic [W-1:0] r_count;

  // Increment every cycle; natural wrap at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= '0;
    else        r_count <= r_count + W'(1);
  end

  assign count_o = r_count;

endmodule

// File: rtl/assert_fail_sequencer.sv
// Assertion failure sequencer: registers the failure term (stop|ucf),
// latches the first cause and its timestamp, waits an optional hold-off,
// requests a halt from the clock controller and then presents a one-shot
// report to the host.
// Optional feature macro: AFS_FAILURE_COUNT_EN adds fail_cnt_o, a saturating
// count of failure rising edges.
//
// Handshakes: halt_req_o stays high for as long as the FSM is in HALT and
// the request completes on any cycle where halt_ack_i is high (including
// the first HALT cycle). The report is a valid/ready pair: rpt_valid_o
// stays high with cause/ts stable until a cycle with rpt_valid_o &
// rpt_ready_i, which is the transfer; the FSM returns to IDLE after it.
module assert_fail_sequencer
  import afs_pkg::*;
#(
  parameter int TS_W      = TS_W_DEF,
  parameter int HOLDOFF_W = HOLDOFF_W_DEF
`ifdef AFS_FAILURE_COUNT_EN
  , parameter int CNT_W   = CNT_W_DEF
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm_i,
  input  logic                 clear_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  input  logic                 stop_i,
  input  logic                 ucf_i,
  output logic                 failure_o,
  output logic                 halt_req_o,
  input  logic                 halt_ack_i,
  output logic                 rpt_valid_o,
  input  logic                 rpt_ready_i,
  output logic [1:0]           rpt_cause_o,
  output logic [TS_W-1:0]      rpt_ts_o,
  output logic [2:0]           state_o
`ifdef AFS_FAILURE_COUNT_EN
  , output logic [CNT_W-1:0]   fail_cnt_o
`endif
);

  afs_state_e            r_state;
  afs_state_e            w_state_nxt;
  logic [HOLDOFF_W-1:0]  r_cnt;
  logic [HOLDOFF_W-1:0]  w_cnt_nxt;
  logic                  w_fail;
  logic                  w_capture;
  logic                  r_failure;
  logic [1:0]            r_cause;
  logic [TS_W-1:0]       r_ts;
  logic [TS_W-1:0]       w_ts;

  assign w_fail = stop_i | ucf_i;

  afs_timestamp_ctr #(.W(TS_W)) u_ts (
    .clk     (clk),
    .rst_n   (rst_n),
    .count_o (w_ts)
  );

  // Registered copy of the failure term; also the previous-cycle value for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_failure <= 1'b0;
    else        r_failure <= w_fail;
  end

  // FSM state and hold-off counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; clear_i overrides any transition
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    if (clear_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Failures here are ignored; only arming moves on
          if (arm_i) w_state_nxt = ST_ARMED;
        end
        ST_ARMED: begin
          // A failure in the same cycle as disarm still counts
          if (w_fail) begin
            w_capture = 1'b1;
            if (holdoff_i == '0) begin
              w_state_nxt = ST_HALT;
            end else begin
              w_state_nxt = ST_HOLDOFF;
              w_cnt_nxt   = holdoff_i;
            end
          end else if (!arm_i) begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HOLDOFF: begin
          w_cnt_nxt = r_cnt - HOLDOFF_W'(1);
          if (r_cnt == HOLDOFF_W'(1)) w_state_nxt = ST_HALT;
        end
        ST_HALT: begin
          if (halt_ack_i) w_state_nxt = ST_REPORT;
        end
        ST_REPORT: begin
          // rpt_valid_o is high throughout REPORT, so ready alone completes the transfer
          if (rpt_ready_i) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // First-failure capture; frozen until the next capture in ARMED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cause <= '0;
      r_ts    <= '0;
    end else if (w_capture) begin
      r_cause <= make_cause(stop_i, ucf_i);
      r_ts    <= w_ts;
    end
  end

  assign failure_o   = r_failure;
  assign halt_req_o  = (r_state == ST_HALT);
  assign rpt_valid_o = (r_state == ST_REPORT);
  assign rpt_cause_o = r_cause;
  assign rpt_ts_o    = r_ts;
  assign state_o     = r_state;

`ifdef AFS_FAILURE_COUNT_EN
  logic [CNT_W-1:0] r_fail_cnt;

  // Saturating count of failure rising edges in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          r_fail_cnt <= '0;
    else if (clear_i)                                    r_fail_cnt <= '0;
    else if (w_fail && !r_failure && (r_fail_cnt != '1)) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
  end

  assign fail_cnt_o = r_fail_cnt;
`endif

endmodule

// File: tb/tb_assert_fail_sequencer.sv
// Directed bench for assert_fail_sequencer. A narrow timestamp makes the
// wrap reachable in a few hundred cycles; a local cycle counter supplies
// the expected timestamps. Inputs change and outputs are sampled on the
// falling edge.
module tb_assert_fail_sequencer;

  localparam int TS_W      = 8;
  localparam int HOLDOFF_W = 8;
  localparam int W         = TS_W + 2;
`ifdef AFS_FAILURE_COUNT_EN
  localparam int CNT_W     = 2;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 arm_i;
  logic                 clear_i;
  logic [HOLDOFF_W-1:0] holdoff_i;
  logic                 stop_i;
  logic                 ucf_i;
  logic                 failure_o;
  logic                 halt_req_o;
  logic                 halt_ack_i;
  logic                 rpt_valid_o;
  logic                 rpt_ready_i;
  logic [1:0]           rpt_cause_o;
  logic [TS_W-1:0]      rpt_ts_o;
  logic [2:0]           state_o;
`ifdef AFS_FAILURE_COUNT_EN
  logic [CNT_W-1:0]     fail_cnt_o;
`endif

  logic [W-1:0]    exp_q[$];
  logic [TS_W-1:0] ts_model;
  int              n_checks;
  int              n_pass;
  int              n_fail;

  assert_fail_sequencer #(
    .TS_W      (TS_W),
    .HOLDOFF_W (HOLDOFF_W)
`ifdef AFS_FAILURE_COUNT_EN
    , .CNT_W   (CNT_W)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm_i       (arm_i),
    .clear_i     (clear_i),
    .holdoff_i   (holdoff_i),
    .stop_i      (stop_i),
    .ucf_i       (ucf_i),
    .failure_o   (failure_o),
    .halt_req_o  (halt_req_o),
    .halt_ack_i  (halt_ack_i),
    .rpt_valid_o (rpt_valid_o),
    .rpt_ready_i (rpt_ready_i),
    .rpt_cause_o (rpt_cause_o),
    .rpt_ts_o    (rpt_ts_o),
    .state_o     (state_o)
`ifdef AFS_FAILURE_COUNT_EN
    , .fail_cnt_o (fail_cnt_o)
`endif
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected timestamp: the value the counter holds during the current cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_model <= '0;
    else        ts_model <= ts_model + 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ts(input logic [TS_W-1:0] t);
    int k;
    k = 0;
    while (ts_model != t && k < 300) begin
      tick();
      k++;
    end
    check("wait_ts", 64'(ts_model), 64'(t));
  endtask

  task automatic wait_halt(input string tag, input logic [TS_W-1:0] t);
    int k;
    k = 0;
    while (!halt_req_o && k < 300) begin
      tick();
      k++;
    end
    check(tag, 64'(ts_model), 64'(t));
  endtask

  task automatic accept_report(input string tag);
    int k;
    logic [W-1:0] exp;
    k = 0;
    while (!rpt_valid_o && k < 50) begin
      tick();
      k++;
    end
    check({tag, "_valid"}, 64'(rpt_valid_o), 64'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, "_payload"}, 64'({rpt_cause_o, rpt_ts_o}), 64'(exp));
    rpt_ready_i = 1'b1;
    tick();
    rpt_ready_i = 1'b0;
    check({tag, "_idle"}, 64'(state_o), 64'd0);
    check({tag, "_valid_low"}, 64'(rpt_valid_o), 64'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    arm_i       = 1'b0;
    clear_i     = 1'b0;
    holdoff_i   = '0;
    stop_i      = 1'b0;
    ucf_i       = 1'b0;
    halt_ack_i  = 1'b0;
    rpt_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_outputs", 64'({failure_o, halt_req_o, rpt_valid_o, rpt_cause_o, rpt_ts_o}), 64'd0);

    // Stop at ts=100, no hold-off -> halt at 101, cause 10
    arm_i = 1'b1;
    tick();
    check("armed", 64'(state_o), 64'd1);
    wait_ts(8'd100);
    stop_i = 1'b1;
    exp_q.push_back({2'b10, 8'd100});
    tick();
    stop_i = 1'b0;
    check("t1_failure_o", 64'(failure_o), 64'd1);
    wait_halt("t1_halt_ts", 8'd101);
    check("t1_state_halt", 64'(state_o), 64'd3);
    halt_ack_i = 1'b1;
    tick();
    halt_ack_i = 1'b0;
    check("t1_state_report", 64'(state_o), 64'd4);
    accept_report("t1_rpt");

    // Hold-off 5: ucf at 20 (after wrap), later stop ignored -> halt at 26
    holdoff_i = 8'd5;
    tick();
    check("t2_armed", 64'(state_o), 64'd1);
    wait_ts(8'd20);
    ucf_i = 1'b1;
    exp_q.push_back({2'b01, 8'd20});
    tick();
    ucf_i     = 1'b0;
    holdoff_i = 8'd0;
    check("t2_holdoff", 64'(state_o), 64'd2);
    tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    wait_halt("t2_halt_ts", 8'd26);
    halt_ack_i = 1'b1;
    tick();
    halt_ack_i = 1'b0;
    accept_report("t2_rpt");

    // Both causes at ts=255, ack already high in the first HALT cycle, slow host
    halt_ack_i = 1'b1;
    wait_ts(8'd255);
    stop_i = 1'b1;
    ucf_i  = 1'b1;
    exp_q.push_back({2'b11, 8'd255});
    tick();
    stop_i = 1'b0;
    ucf_i  = 1'b0;
    check("t3_halt_req", 64'(halt_req_o), 64'd1);
    check("t3_ts_wrapped", 64'(ts_model), 64'd0);
    tick();
    halt_ack_i = 1'b0;
    arm_i      = 1'b0;
    check("t3_state_report", 64'(state_o), 64'd4);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", 64'(rpt_valid_o), 64'd1);
      check("t3_hold_payload", 64'({rpt_cause_o, rpt_ts_o}), 64'(exp_q[0]));
      tick();
    end
    accept_report("t3_rpt");

    // Failure in IDLE: failure_o follows, no halt
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("idle_failure_o", 64'(failure_o), 64'd1);
    check("idle_state", 64'(state_o), 64'd0);
    tick();
    check("idle_failure_o_low", 64'(failure_o), 64'd0);
    check("idle_no_halt", 64'(halt_req_o), 64'd0);

    // Disarm with a coincident failure still captures; clear in HALT aborts
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    ucf_i = 1'b1;
    tick();
    ucf_i = 1'b0;
    check("disarm_capture_halt", 64'(state_o), 64'd3);
    check("disarm_cause", 64'(rpt_cause_o), 64'd1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clear_halt_req", 64'(halt_req_o), 64'd0);
    check("clear_state", 64'(state_o), 64'd0);

`ifdef AFS_FAILURE_COUNT_EN
    // Five failure edges against a 2-bit saturating counter
    check("cnt_after_clear", 64'(fail_cnt_o), 64'd0);
    for (int i = 0; i < 5; i++) begin
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      tick();
    end
    check("cnt_saturate", 64'(fail_cnt_o), 64'd3);
`endif

    // Asynchronous reset in HALT drops the request immediately
    arm_i = 1'b1;
    tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("pre_reset_halt", 64'(halt_req_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_halt", 64'(halt_req_o), 64'd0);
    check("async_rst_state", 64'(state_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
